// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand and result handshake bundle for serial_subtractor.
//   in_valid/in_ready/a/b        : operand channel (producer -> subtractor)
//   out_valid/out_ready/d/borrow : result channel (subtractor -> consumer)
//   ovf                          : signed overflow, only with SERIAL_SUB_OVF_EN
// Modports: master = producer/consumer side, slave = the subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, d, borrow, ovf
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, d, borrow, ovf
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, d, borrow
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, d, borrow
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full-subtractor cell
// plus a borrow flop. One bit per clock over WIDTH cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (priority over all handshakes)
//   bus  : serial_subtractor_if.slave (operand and result handshakes)
// Optional feature macro: SERIAL_SUB_OVF_EN adds the registered signed
// overflow flag bus.ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             bw_q;
  logic [CNT_W-1:0] cnt_q;

  logic             dbit_d;
  logic             bw_d;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_sgn_q;
  logic             b_sgn_q;
  logic             ovf_q;
`endif

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    dbit_d = a_q[0] ^ b_q[0] ^ bw_q;
    bw_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      bw_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_sgn_q <= 1'b0;
      b_sgn_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready is IDLE & ~rst, and rst is low here.
          if (bus.in_valid) begin
            state_q <= SHIFT;
            a_q     <= bus.a;
            b_q     <= bus.b;
            res_q   <= '0;
            bw_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_sgn_q <= bus.a[WIDTH-1];
            b_sgn_q <= bus.b[WIDTH-1];
            ovf_q   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          // Enter at the MSB; after WIDTH shifts bit 0 has reached position 0.
          res_q <= {dbit_d, res_q[WIDTH-1:1]};
          bw_q  <= bw_d;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            // dbit_d is the final result MSB on this cycle.
            ovf_q   <= (a_sgn_q != b_sgn_q) & (dbit_d != a_sgn_q);
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) & ~rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.d         = res_q;
  assign bus.borrow    = bw_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) intf ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  typedef struct {
    int unsigned d;
    int unsigned bw;
    int unsigned ov;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   windows = 0;
  int   last_acc = 0;
  int   ready_mode = 1; // 0: hold low, 1: hold high, 2: random

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int unsigned av, input int unsigned bv);
    exp_t e;
    int   sa, sb, diff;
    int   half;
    half = 1 << (W - 1);
    e.d  = (av + (1 << W) - bv) % (1 << W);
    e.bw = (av < bv) ? 1 : 0;
    sa   = (av >= half) ? int'(av) - (1 << W) : int'(av);
    sb   = (bv >= half) ? int'(bv) - (1 << W) : int'(bv);
    diff = sa - sb;
    e.ov = (diff < -half || diff > half - 1) ? 1 : 0;
    e.acc = 0;
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    case (ready_mode)
      0:       intf.out_ready = 1'b0;
      1:       intf.out_ready = 1'b1;
      default: intf.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops on the first cycle of each result window, then checks
  // that the window holds steady until released.
  initial begin
    bit          seen;
    logic [W-1:0] hold_d;
    logic        hold_b;
    exp_t        e;
    seen = 0;
    hold_d = '0;
    hold_b = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && intf.out_valid === 1'b1) begin
        if (!seen) begin
          seen = 1;
          windows++;
          hold_d = intf.d;
          hold_b = intf.borrow;
          if (sb_q.size() == 0) begin
            fail("unexpected_result_window");
          end else begin
            e = sb_q.pop_front();
            chk("result_d", intf.d, e.d);
            chk("result_borrow", intf.borrow, e.bw);
`ifdef SERIAL_SUB_OVF_EN
            chk("result_ovf", intf.ovf, e.ov);
`endif
            chk("latency_edges", cyc - e.acc, W);
          end
        end else begin
          chk("hold_d", intf.d, hold_d);
          chk("hold_borrow", intf.borrow, hold_b);
          chk("in_ready_in_done", intf.in_ready, 0);
        end
      end else begin
        seen = 0;
      end
    end
  end

  task automatic send(input int unsigned av, input int unsigned bv);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (intf.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (intf.in_ready !== 1'b1) begin
      fail("in_ready_timeout");
    end else begin
      intf.in_valid = 1'b1;
      intf.a = W'(av);
      intf.b = W'(bv);
      @(posedge clk);
      e = model(av, bv);
      @(negedge clk);
      e.acc = cyc;
      last_acc = cyc;
      sb_q.push_back(e);
      intf.in_valid = 1'b0;
      intf.a = W'($urandom);
      intf.b = W'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(sb_q.size() == 0 && intf.out_valid === 1'b0 && intf.in_ready === 1'b1) && n < 500);
    if (n >= 500) fail("idle_timeout");
  endtask

  initial begin
    int w0;
    int acc1;
    int n;
    intf.in_valid = 1'b0;
    intf.a = '0;
    intf.b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", intf.in_ready, 0);
    chk("rst_out_valid", intf.out_valid, 0);
    chk("rst_d", intf.d, 0);
    chk("rst_borrow", intf.borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", intf.ovf, 0);
`endif
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", intf.in_ready, 1);

    // Basic op, single-cycle window with out_ready high
    ready_mode = 1;
    w0 = windows;
    send(9, 3);
    n = 0;
    while (windows == w0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (windows == w0) fail("first_window_timeout");
    @(negedge clk);
    #1;
    chk("window_one_cycle", intf.out_valid, 0);

    // Back-to-back with out_ready high: minimum initiation interval
    send(3, 9);
    acc1 = last_acc;
    send(0, 1);
    chk("init_interval", last_acc - acc1, W + 2);
    send(0, 0);
    wait_idle();

    // Back-pressure
    ready_mode = 0;
    send(12, 5);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (intf.out_valid !== 1'b1 && n < 50);
    if (intf.out_valid !== 1'b1) fail("bp_window_timeout");
    repeat (10) @(negedge clk);
    #1;
    chk("bp_still_valid", intf.out_valid, 1);
    chk("bp_d", intf.d, 7);
    ready_mode = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("bp_release_in_ready", intf.in_ready, 1);
    chk("bp_release_out_valid", intf.out_valid, 0);

    // Operands offered during SHIFT are ignored
    w0 = windows;
    send(5, 2);
    intf.in_valid = 1'b1;
    intf.a = W'(1);
    intf.b = W'(1);
    repeat (3) @(negedge clk);
    intf.in_valid = 1'b0;
    wait_idle();
    repeat (W + 3) @(negedge clk);
    chk("ignored_single_window", windows - w0, 1);

    // Reset in the 2nd SHIFT cycle aborts
    w0 = windows;
    send(6, 3);
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    #1;
    chk("abort_in_ready_rst", intf.in_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("abort_no_out_valid", intf.out_valid, 0);
    end
    chk("abort_d", intf.d, 0);
    chk("abort_borrow", intf.borrow, 0);
    chk("abort_windows", windows - w0, 0);
    send(15, 15);
    wait_idle();

    // Signed-overflow corners
    send(8, 1);
    send(7, 15);
    send(5, 3);
    wait_idle();

    // Randomized traffic with random back-pressure
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1));
    end
    ready_mode = 1;
    wait_idle();
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
